// File: rtl/if_stage_pkg.sv
// Shared widths, reset address and bus layouts for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned BR_BUS_WD       = 33;
  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_bus_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage boundary: decode handshake, branch bus and instruction SRAM port.
interface if_stage_if;
  import if_stage_pkg::*;

  logic          ds_allowin;
  br_bus_t       br_bus;
  logic          fs_to_ds_valid;
  fs_to_ds_bus_t fs_to_ds_bus;
  logic          inst_sram_en;
  logic [3:0]    inst_sram_we;
  logic [31:0]   inst_sram_addr;
  logic [31:0]   inst_sram_wdata;
  logic [31:0]   inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
           inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, SRAM request, stall hold and branch redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  if_stage_if.master fs
);

  logic        resetn_q;
  logic        fs_valid;
  logic        fs_cancel;
  logic        br_pend;
  logic        buf_vld;
  logic [31:0] fs_pc;
  logic [31:0] pend_target;
  logic [31:0] inst_buf;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        to_fs_valid;
  logic        fs_allowin;
  logic        fetch_req;

  assign to_fs_valid = resetn_q;
  // A cancelled slot is dropped rather than offered, so it never blocks the redirect.
  assign fs_allowin  = !fs_valid | fs.ds_allowin | fs_cancel;
  assign fetch_req   = to_fs_valid & fs_allowin;

  always_comb begin
    if (fs.br_bus.taken)  nextpc = fs.br_bus.target;
    else if (br_pend)     nextpc = pend_target;
    else                  nextpc = fs_pc + 32'd4;
  end

  assign fs_inst = buf_vld ? inst_buf : fs.inst_sram_rdata;

  assign fs.inst_sram_en    = resetn & fetch_req;
  assign fs.inst_sram_we    = 4'h0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'h0;
  assign fs.fs_to_ds_valid  = resetn & fs_valid & !fs_cancel;
  assign fs.fs_to_ds_bus    = '{inst: fs_inst, pc: fs_pc};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resetn_q  <= 1'b0;
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      br_pend   <= 1'b0;
      fs_cancel <= 1'b0;
      buf_vld   <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
      if (fs_allowin) begin
        fs_valid  <= to_fs_valid;
        fs_cancel <= 1'b0;
        buf_vld   <= 1'b0;
        br_pend   <= 1'b0;
        // Only advance the PC when a request actually went out, so the first
        // post-reset fetch is exactly RESET_PC.
        if (to_fs_valid) fs_pc <= nextpc;
      end else begin
        if (fs.br_bus.taken) begin
          br_pend   <= 1'b1;
          fs_cancel <= fs_valid;
        end
        if (!buf_vld) buf_vld <= 1'b1;
      end
    end
  end

  // NOTE: payload registers carry no reset; they are only read while their
  // qualifying flag (br_pend / buf_vld) is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (resetn && !fs_allowin) begin
      if (fs.br_bus.taken) pend_target <= fs.br_bus.target;
      if (!buf_vld)        inst_buf    <= fs.inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall hold, redirects, PC wrap, mid-stall reset.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic garble = 1'b0;
  logic [31:0] rdata_q = 32'h0;
  int n_cmp = 0;
  int n_err = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fs     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_a5a5;
  endfunction

  // Synchronous SRAM model with a 1-cycle read; garble corrupts the returned word.
  always @(posedge clk) begin
    if (bus.inst_sram_en) rdata_q <= inst_of(bus.inst_sram_addr);
  end
  assign bus.inst_sram_rdata = garble ? 32'hdead_beef : rdata_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ds, input logic brt, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    resetn         = rst;
    bus.ds_allowin = ds;
    bus.br_bus     = '{taken: brt, target: tgt};
    #1;
  endtask

  task automatic chk_req(input string tag, input logic en, input logic [31:0] addr);
    check({tag, ".en"}, 64'(bus.inst_sram_en), 64'(en));
    if (en) check({tag, ".addr"}, 64'(bus.inst_sram_addr), 64'(addr));
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(bus.fs_to_ds_valid), 64'(vld));
    if (vld) check({tag, ".bus"}, 64'(bus.fs_to_ds_bus), {inst_of(pc), pc});
  endtask

  initial begin
    resetn         = 1'b0;
    bus.ds_allowin = 1'b1;
    bus.br_bus     = '0;

    // Reset, then release
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_req("rst", 0, 0);
    chk_out("rst", 0, 0);
    check("rst.we_wdata", {28'h0, bus.inst_sram_we, bus.inst_sram_wdata}, 64'h0);
    step(1, 1, 0, 0);
    chk_req("rel0", 0, 0);
    step(1, 1, 0, 0);
    chk_req("rel1", 1, 32'h1c00_0000);
    chk_out("rel1", 0, 0);
    step(1, 1, 0, 0);
    chk_out("seq0", 1, 32'h1c00_0000);
    chk_req("seq0", 1, 32'h1c00_0004);
    step(1, 1, 0, 0);
    chk_out("seq1", 1, 32'h1c00_0004);
    chk_req("seq1", 1, 32'h1c00_0008);

    // Three-cycle stall holding 0x1c000008, rdata corrupted after the first stall cycle
    step(1, 0, 0, 0);
    chk_out("stall0", 1, 32'h1c00_0008);
    chk_req("stall0", 0, 0);
    step(1, 0, 0, 0);
    garble = 1'b1;
    #1;
    chk_out("stall1", 1, 32'h1c00_0008);
    chk_req("stall1", 0, 0);
    step(1, 0, 0, 0);
    chk_out("stall2", 1, 32'h1c00_0008);
    step(1, 1, 0, 0);
    chk_out("resume", 1, 32'h1c00_0008);
    chk_req("resume", 1, 32'h1c00_000c);
    garble = 1'b0;

    // Taken branch while decode accepts
    step(1, 1, 1, 32'h1c00_0100);
    chk_out("br_now", 1, 32'h1c00_000c);
    chk_req("br_now", 1, 32'h1c00_0100);
    step(1, 1, 0, 0);
    chk_out("br_tgt", 1, 32'h1c00_0100);
    chk_req("br_tgt", 1, 32'h1c00_0104);

    // Taken branch during a stall: stale slot dropped, pending target fetched next
    step(1, 0, 1, 32'h1c00_0200);
    chk_req("brst0", 0, 0);
    step(1, 0, 0, 0);
    chk_out("brst1", 0, 0);
    chk_req("brst1", 1, 32'h1c00_0200);
    step(1, 0, 0, 0);
    chk_out("brst2", 1, 32'h1c00_0200);
    chk_req("brst2", 0, 0);
    step(1, 1, 0, 0);
    chk_out("brst3", 1, 32'h1c00_0200);
    chk_req("brst3", 1, 32'h1c00_0204);

    // PC wrap past 0xfffffffc
    step(1, 1, 1, 32'hffff_fffc);
    chk_req("wrap0", 1, 32'hffff_fffc);
    step(1, 1, 0, 0);
    chk_out("wrap1", 1, 32'hffff_fffc);
    chk_req("wrap1", 1, 32'h0000_0000);
    step(1, 1, 0, 0);
    chk_out("wrap2", 1, 32'h0000_0000);

    // Reset mid-stall with a branch pending
    step(1, 0, 0, 0);
    chk_out("mrst0", 1, 32'h0000_0004);
    step(1, 0, 1, 32'h1c00_0300);
    step(0, 0, 0, 0);
    chk_req("mrst_in", 0, 0);
    chk_out("mrst_in", 0, 0);
    step(1, 1, 0, 0);
    chk_req("mrst_rel0", 0, 0);
    chk_out("mrst_rel0", 0, 0);
    step(1, 1, 0, 0);
    chk_req("mrst_rel1", 1, 32'h1c00_0000);
    chk_out("mrst_rel1", 0, 0);
    step(1, 1, 0, 0);
    chk_out("mrst_rel2", 1, 32'h1c00_0000);
    chk_req("mrst_rel2", 1, 32'h1c00_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
